// File: rtl/regfile_if.sv
// -----------------------------------------------------------------------------
// regfile_if -- operand/result bus between the ALU side and the register file.
//
// Data width follows the shared `WIDTH macro (default 8), the same one the ALU
// uses. Address width is fixed at 5 bits (32 registers).
//
// Signals:
//   wr_en, wr_addr, wr_data     write strobe, destination, ALU result
//   flag_en, carry_in, zero_in  flag capture strobe and ALU flags
//   rd_req, rd_addr_a/b         operand fetch request and source addresses
//   rd_data_a/b, rd_valid       registered operands and their valid flag
//   carry_q, zero_q             stored flags
//
// Modports:
//   master -- drives writes, flags and fetch requests (ALU / sequencer side)
//   slave  -- the register file itself
// -----------------------------------------------------------------------------
`ifndef WIDTH
`define WIDTH 8
`endif

interface regfile_if #(
  parameter int WIDTH  = `WIDTH,
  parameter int ADDR_W = 5
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              flag_en;
  logic              carry_in;
  logic              zero_in;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [WIDTH-1:0]  rd_data_a;
  logic [WIDTH-1:0]  rd_data_b;
  logic              rd_valid;
  logic              carry_q;
  logic              zero_q;

  modport master (
    output wr_en, wr_addr, wr_data,
    output flag_en, carry_in, zero_in,
    output rd_req, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, rd_valid,
    input  carry_q, zero_q
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  flag_en, carry_in, zero_in,
    input  rd_req, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, rd_valid,
    output carry_q, zero_q
  );
endinterface

// File: rtl/regfile.sv
// -----------------------------------------------------------------------------
// regfile -- 32-entry general purpose register file with two registered read
// ports, one write port and a carry/zero flag register.
//
// Ports:
//   clk    single clock, all state updates on the rising edge
//   rst_n  asynchronous active-low reset, clears all state and outputs
//   bus    regfile_if.slave (write port, flag capture, two-port fetch)
//
// Behaviour:
//   - Register 0 reads as zero; writes to it are dropped.
//   - A fetch (rd_req=1) in cycle N presents rd_data_a/b with rd_valid=1 in
//     cycle N+1. Without a request, rd_valid drops and the data holds.
//   - Flags load on flag_en, independently of wr_en.
//
// Configuration macro:
//   REGFILE_BYPASS_EN  when defined, a fetch of the register being written in
//                      the same cycle returns the incoming wr_data; when
//                      undefined, it returns the previously stored value.
// -----------------------------------------------------------------------------
`ifndef WIDTH
`define WIDTH 8
`endif

module regfile #(
  parameter int WIDTH    = `WIDTH,
  parameter int NUM_REGS = 32
) (
  input logic      clk,
  input logic      rst_n,
  regfile_if.slave bus
);

  localparam int ADDR_W = 5;

  logic [WIDTH-1:0] mem_r [NUM_REGS];
  logic [WIDTH-1:0] rd_sel_a_s;
  logic [WIDTH-1:0] rd_sel_b_s;
  logic [WIDTH-1:0] rd_data_a_r;
  logic [WIDTH-1:0] rd_data_b_r;
  logic             rd_valid_r;
  logic             carry_r;
  logic             zero_r;

  // Register array write port; entry 0 is cleared by reset and never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (bus.wr_en && (bus.wr_addr != {ADDR_W{1'b0}})) begin
      mem_r[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Port A operand select: zero register, optional write bypass, stored value.
  always_comb begin
    rd_sel_a_s = {WIDTH{1'b0}};
    if (bus.rd_addr_a == {ADDR_W{1'b0}}) begin
      rd_sel_a_s = {WIDTH{1'b0}};
`ifdef REGFILE_BYPASS_EN
    end else if (bus.wr_en && (bus.wr_addr == bus.rd_addr_a)) begin
      rd_sel_a_s = bus.wr_data;
`endif
    end else begin
      rd_sel_a_s = mem_r[bus.rd_addr_a];
    end
  end

  // Port B operand select: same rules as port A.
  always_comb begin
    rd_sel_b_s = {WIDTH{1'b0}};
    if (bus.rd_addr_b == {ADDR_W{1'b0}}) begin
      rd_sel_b_s = {WIDTH{1'b0}};
`ifdef REGFILE_BYPASS_EN
    end else if (bus.wr_en && (bus.wr_addr == bus.rd_addr_b)) begin
      rd_sel_b_s = bus.wr_data;
`endif
    end else begin
      rd_sel_b_s = mem_r[bus.rd_addr_b];
    end
  end

  // Operand output registers: capture on request, otherwise hold data and
  // drop valid. Reset clears everything so a cancelled fetch leaves no trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_a_r <= {WIDTH{1'b0}};
      rd_data_b_r <= {WIDTH{1'b0}};
      rd_valid_r  <= 1'b0;
    end else if (bus.rd_req) begin
      rd_data_a_r <= rd_sel_a_s;
      rd_data_b_r <= rd_sel_b_s;
      rd_valid_r  <= 1'b1;
    end else begin
      rd_valid_r  <= 1'b0;
    end
  end

  // Flag register: loads on flag_en, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_r <= 1'b0;
      zero_r  <= 1'b0;
    end else if (bus.flag_en) begin
      carry_r <= bus.carry_in;
      zero_r  <= bus.zero_in;
    end
  end

  assign bus.rd_data_a = rd_data_a_r;
  assign bus.rd_data_b = rd_data_b_r;
  assign bus.rd_valid  = rd_valid_r;
  assign bus.carry_q   = carry_r;
  assign bus.zero_q    = zero_r;

endmodule
